la_ram_write_arbiter: RTL

- Sits between the two logic analyzer pod capture paths (la0/la1 RAM write ports) and the DDR3 controller's native application write interface.
- Queues 128-bit write requests from each pod in a small per-client FIFO.
- Arbitrates round-robin between the two clients and issues one write command plus one data beat per request.
- Returns a per-client ack pulse for each request once both the command and the data beat have been accepted.

---
 rtl/la_ram_write_arbiter.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/la_ram_write_arbiter.sv
// ---------------------------------------------------------------------------
// la_ram_write_arbiter
//
// Merges the RAM write streams of the two logic-analyzer pod capture paths
// onto the native application write interface of the DDR3 controller.
// Each client owns a small FIFO of {addr, data} entries. A round-robin
// arbiter picks a non-empty FIFO, presents one write command and one data
// beat, and returns a one-cycle ack to the owning client once the controller
// has accepted both.
//
// Ports
//   clk_ram, rst_n            controller user clock, synchronous active-low reset
//   ram_ready                 calibration complete; gates new grants only
//   laN_wr_en/addr/data       one-cycle write request from client N
//   laN_wr_ack                one-cycle completion pulse, in request order
//   laN_overflow              sticky: a request was dropped on a full FIFO
//   app_en/cmd/addr/rdy       controller command channel
//   app_wdf_wren/data/end/mask/rdy   controller write data channel
//
// Optional build macro
//   LA_ARB_STATS_EN           adds la0_write_count, la1_write_count and
//                             stall_count (32-bit, saturating)
//
// state   | meaning
// --------+-------------------------------------------------------------------
// S_IDLE  | waiting for ram_ready and a queued request; loads the head entry
// S_ISSUE | command and/or data beat outstanding until both are accepted
// ---------------------------------------------------------------------------
module la_ram_write_arbiter #(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_WIDTH = 29,
   parameter int DATA_WIDTH = 128
) (
   input  logic                      clk_ram,
   input  logic                      rst_n,
   input  logic                      ram_ready,

   input  logic                      la0_wr_en,
   input  logic [ADDR_WIDTH-1:0]     la0_wr_addr,
   input  logic [DATA_WIDTH-1:0]     la0_wr_data,
   output logic                      la0_wr_ack,

   input  logic                      la1_wr_en,
   input  logic [ADDR_WIDTH-1:0]     la1_wr_addr,
   input  logic [DATA_WIDTH-1:0]     la1_wr_data,
   output logic                      la1_wr_ack,

   output logic                      app_en,
   output logic [2:0]                app_cmd,
   output logic [ADDR_WIDTH-1:0]     app_addr,
   input  logic                      app_rdy,
   output logic                      app_wdf_wren,
   output logic [DATA_WIDTH-1:0]     app_wdf_data,
   output logic                      app_wdf_end,
   output logic [DATA_WIDTH/8-1:0]   app_wdf_mask,
   input  logic                      app_wdf_rdy,

   output logic                      la0_overflow,
   output logic                      la1_overflow
`ifdef LA_ARB_STATS_EN
   ,
   output logic [31:0]               la0_write_count,
   output logic [31:0]               la1_write_count,
   output logic [31:0]               stall_count
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = ADDR_WIDTH + DATA_WIDTH;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_ISSUE = 1'b1
   } state_t;

   state_t state;

   // Write-only single-beat bursts: command and mask never change.
   assign app_cmd      = 3'b000;
   assign app_wdf_mask = '0;
   assign app_wdf_end  = app_wdf_wren;

   // ------------------------------------------------------------------------
   // Client 0 FIFO
   // ------------------------------------------------------------------------
   logic [ENT_W-1:0] fifo0_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] fifo0_wr_ptr;
   logic [PTR_W-1:0] fifo0_rd_ptr;
   logic [CNT_W-1:0] fifo0_count;
   logic             fifo0_full;
   logic             fifo0_empty;
   logic             fifo0_push;
   logic             fifo0_pop;
   logic [ENT_W-1:0] fifo0_head;

   // Full is taken from the registered count, so a push that coincides with
   // a pop on a full FIFO is still dropped.
   assign fifo0_full  = (fifo0_count == FULL);
   assign fifo0_empty = (fifo0_count == '0);
   assign fifo0_push  = la0_wr_en && !fifo0_full;
   assign fifo0_head  = fifo0_mem[fifo0_rd_ptr];

   always_ff @(posedge clk_ram) begin
      if (!rst_n) begin
         fifo0_wr_ptr <= '0;
         fifo0_rd_ptr <= '0;
         fifo0_count  <= '0;
         la0_overflow <= 1'b0;
      end else begin
         if (fifo0_push) begin
            fifo0_wr_ptr <= fifo0_wr_ptr + 1'b1;
         end
         if (fifo0_pop) begin
            fifo0_rd_ptr <= fifo0_rd_ptr + 1'b1;
         end
         if (la0_wr_en && fifo0_full) begin
            la0_overflow <= 1'b1;
         end
         case ({fifo0_push, fifo0_pop})
            2'b10:   fifo0_count <= fifo0_count + 1'b1;
            2'b01:   fifo0_count <= fifo0_count - 1'b1;
            default: fifo0_count <= fifo0_count;
         endcase
      end
   end

   always_ff @(posedge clk_ram) begin
      if (fifo0_push) begin
         fifo0_mem[fifo0_wr_ptr] <= {la0_wr_addr, la0_wr_data};
      end
   end

   // ------------------------------------------------------------------------
   // Client 1 FIFO
   // ------------------------------------------------------------------------
   logic [ENT_W-1:0] fifo1_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] fifo1_wr_ptr;
   logic [PTR_W-1:0] fifo1_rd_ptr;
   logic [CNT_W-1:0] fifo1_count;
   logic             fifo1_full;
   logic             fifo1_empty;
   logic             fifo1_push;
   logic             fifo1_pop;
   logic [ENT_W-1:0] fifo1_head;

   assign fifo1_full  = (fifo1_count == FULL);
   assign fifo1_empty = (fifo1_count == '0);
   assign fifo1_push  = la1_wr_en && !fifo1_full;
   assign fifo1_head  = fifo1_mem[fifo1_rd_ptr];

   always_ff @(posedge clk_ram) begin
      if (!rst_n) begin
         fifo1_wr_ptr <= '0;
         fifo1_rd_ptr <= '0;
         fifo1_count  <= '0;
         la1_overflow <= 1'b0;
      end else begin
         if (fifo1_push) begin
            fifo1_wr_ptr <= fifo1_wr_ptr + 1'b1;
         end
         if (fifo1_pop) begin
            fifo1_rd_ptr <= fifo1_rd_ptr + 1'b1;
         end
         if (la1_wr_en && fifo1_full) begin
            la1_overflow <= 1'b1;
         end
         case ({fifo1_push, fifo1_pop})
            2'b10:   fifo1_count <= fifo1_count + 1'b1;
            2'b01:   fifo1_count <= fifo1_count - 1'b1;
            default: fifo1_count <= fifo1_count;
         endcase
      end
   end

   always_ff @(posedge clk_ram) begin
      if (fifo1_push) begin
         fifo1_mem[fifo1_wr_ptr] <= {la1_wr_addr, la1_wr_data};
      end
   end

   // ------------------------------------------------------------------------
   // Arbiter / issue FSM
   // ------------------------------------------------------------------------
   // last_grant doubles as the owner of the in-flight write while in S_ISSUE.
   logic last_grant;
   logic next_grant;
   logic cmd_done;
   logic data_done;
   logic cmd_fire;
   logic data_fire;
   logic both_done;
   logic start;

   assign cmd_fire  = app_en && app_rdy;
   assign data_fire = app_wdf_wren && app_wdf_rdy;
   // Either handshake may complete before, after or with the other one.
   assign both_done = (state == S_ISSUE) && (cmd_done || cmd_fire) && (data_done || data_fire);
   assign start     = (state == S_IDLE) && ram_ready && (!fifo0_empty || !fifo1_empty);
   assign fifo0_pop = both_done && !last_grant;
   assign fifo1_pop = both_done && last_grant;

   always_comb begin
      next_grant = 1'b0;
      if (!fifo0_empty && !fifo1_empty) begin
         next_grant = !last_grant;
      end else if (!fifo1_empty) begin
         next_grant = 1'b1;
      end
   end

   always_ff @(posedge clk_ram) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         last_grant   <= 1'b1;
         cmd_done     <= 1'b0;
         data_done    <= 1'b0;
         app_en       <= 1'b0;
         app_wdf_wren <= 1'b0;
         app_addr     <= '0;
         app_wdf_data <= '0;
         la0_wr_ack   <= 1'b0;
         la1_wr_ack   <= 1'b0;
      end else begin
         la0_wr_ack <= 1'b0;
         la1_wr_ack <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  last_grant   <= next_grant;
                  app_addr     <= next_grant ? fifo1_head[ENT_W-1:DATA_WIDTH]
                                             : fifo0_head[ENT_W-1:DATA_WIDTH];
                  app_wdf_data <= next_grant ? fifo1_head[DATA_WIDTH-1:0]
                                             : fifo0_head[DATA_WIDTH-1:0];
                  app_en       <= 1'b1;
                  app_wdf_wren <= 1'b1;
                  state        <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (cmd_fire) begin
                  cmd_done <= 1'b1;
                  app_en   <= 1'b0;
               end
               if (data_fire) begin
                  data_done    <= 1'b1;
                  app_wdf_wren <= 1'b0;
               end
               if (both_done) begin
                  cmd_done   <= 1'b0;
                  data_done  <= 1'b0;
                  la0_wr_ack <= !last_grant;
                  la1_wr_ack <= last_grant;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef LA_ARB_STATS_EN
   // ------------------------------------------------------------------------
   // Statistics counters, saturating at all-ones
   // ------------------------------------------------------------------------
   logic stall;

   assign stall = (state == S_ISSUE) &&
                  ((app_en && !app_rdy) || (app_wdf_wren && !app_wdf_rdy));

   always_ff @(posedge clk_ram) begin
      if (!rst_n) begin
         la0_write_count <= '0;
         la1_write_count <= '0;
         stall_count     <= '0;
      end else begin
         if (la0_wr_ack && (la0_write_count != '1)) begin
            la0_write_count <= la0_write_count + 32'd1;
         end
         if (la1_wr_ack && (la1_write_count != '1)) begin
            la1_write_count <= la1_write_count + 32'd1;
         end
         if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + 32'd1;
         end
      end
   end
`endif

endmodule
